// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package if_fetch_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;

    localparam logic [31:0] Zero32h = 32'h0000_0000;
    localparam logic        Stop    = 1'b1;
    localparam logic        NotStop = 1'b0;
    localparam logic        Enable  = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StHold = 2'b10
    } fetch_state_e;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [InstAddrBus-1:0] pc_add(input logic [InstAddrBus-1:0] pc,
                                                      input int unsigned step);
        return pc + step;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry {pc, inst} holding register used when a return arrives while IF/ID is stalled.
module if_skid_buf
    import if_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic                   unload_i,
    input  logic                   clear_i,
    input  logic [InstAddrBus-1:0] pc_i,
    input  logic [InstBus-1:0]     inst_i,
    output logic                   valid_o,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o
);

    logic                   valid_q, valid_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstBus-1:0]     inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (clear_i || unload_i) begin
            valid_d = 1'b0;
            pc_d    = Zero32h;
            inst_d  = Zero32h;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= Zero32h;
            inst_q  <= Zero32h;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, drives a req/ack instruction memory and feeds IF/ID,
// absorbing one early return in a skid buffer and honouring branch/flush redirects.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             stall,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    input  logic                   flush_i,
    input  logic [InstAddrBus-1:0] new_pc_i,
    output logic                   imem_req,
    output logic [InstAddrBus-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [InstBus-1:0]     imem_rdata,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
    output logic                   stallreq_o
);

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic                   req_q, req_d;
    logic [InstAddrBus-1:0] addr_q, addr_d;
    logic [InstAddrBus-1:0] out_pc_q, out_pc_d;
    logic [InstBus-1:0]     out_inst_q, out_inst_d;
    logic                   out_valid_q, out_valid_d;
    logic                   discard_q, discard_d;

    logic                   skid_load, skid_unload, skid_clear, skid_valid;
    logic [InstAddrBus-1:0] skid_pc;
    logic [InstBus-1:0]     skid_inst;

    logic                   adv, slot_free, redirect;
    logic [InstAddrBus-1:0] target, pc_next;
    logic                   unused_stall;

    assign unused_stall = ^stall[5:3];

    assign adv       = (stall[0] != Stop) && (stall[1] != Stop);
    assign slot_free = adv || !out_valid_q;
    assign redirect  = flush_i || (branch_flag_i && (stall[2] == NotStop));
    assign target    = flush_i ? new_pc_i : branch_target_i;
    assign pc_next   = pc_add(pc_q, PC_STEP);

    if_skid_buf u_skid (
        .clk      (clk),
        .reset    (reset),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .pc_i     (pc_q),
        .inst_i   (imem_rdata),
        .valid_o  (skid_valid),
        .pc_o     (skid_pc),
        .inst_o   (skid_inst)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_valid_d = out_valid_q;
        discard_d   = discard_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        // Slot consumed by IF/ID (or already empty): bubble unless reloaded below.
        if (slot_free) begin
            out_pc_d    = Zero32h;
            out_inst_d  = Zero32h;
            out_valid_d = 1'b0;
        end

        if (redirect) begin
            pc_d        = target;
            out_pc_d    = Zero32h;
            out_inst_d  = Zero32h;
            out_valid_d = 1'b0;
            skid_clear  = 1'b1;
            unique case (state_q)
                StWait: begin
                    // An in-flight request cannot be withdrawn; drop its data when it lands.
                    if (imem_ack) begin
                        addr_d    = target;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: begin
                    state_d = StWait;
                    req_d   = Enable;
                    addr_d  = target;
                end
            endcase
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StWait;
                    req_d   = Enable;
                    addr_d  = pc_q;
                end
                StWait: begin
                    if (imem_ack) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            addr_d    = pc_q;
                        end else if (slot_free) begin
                            out_pc_d    = pc_q;
                            out_inst_d  = imem_rdata;
                            out_valid_d = 1'b1;
                            pc_d        = pc_next;
                            addr_d      = pc_next;
                        end else begin
                            skid_load = 1'b1;
                            pc_d      = pc_next;
                            req_d     = 1'b0;
                            state_d   = StHold;
                        end
                    end
                end
                StHold: begin
                    if (adv) begin
                        out_pc_d    = skid_pc;
                        out_inst_d  = skid_inst;
                        out_valid_d = skid_valid;
                        skid_unload = 1'b1;
                        req_d       = Enable;
                        addr_d      = pc_q;
                        state_d     = StWait;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            out_pc_q    <= Zero32h;
            out_inst_q  <= Zero32h;
            out_valid_q <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_valid_q <= out_valid_d;
            discard_q   <= discard_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign pc_o       = out_pc_q;
    assign inst_o     = out_inst_q;
    assign stallreq_o = (state_q != StIdle) && !out_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: memory with programmable latency plus an in-order delivery model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        stallreq_o;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .stallreq_o      (stallreq_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;        // next address IF/ID must receive
    int          delivered;
    bit          pending;       // memory has an accepted, unanswered request
    int          lat;
    int          lat_mode;      // <0: random latency 0..3
    logic [31:0] held_addr;
    bit          new_req;
    logic [31:0] new_req_addr;
    logic        obs_req;
    logic [31:0] obs_pc, obs_inst, obs_addr;

    // Never zero for word-aligned addresses, so a zero inst_o always means a bubble.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge, answer memory, drive inputs, update the model.
    task automatic step(input logic [5:0] st, input logic br, input logic [31:0] bt,
                        input logic fl, input logic [31:0] np);
        logic ack_v;
        @(negedge clk);
        obs_req  = imem_req;
        obs_pc   = pc_o;
        obs_inst = inst_o;
        obs_addr = imem_addr;
        check32("stallreq", {31'b0, stallreq_o}, {31'b0, (inst_o == 32'h0)});
        if (pending) begin
            check32("req_held", {31'b0, imem_req}, 32'd1);
            check32("addr_held", imem_addr, held_addr);
        end
        ack_v = 1'b0;
        if (imem_req) begin
            if (!pending) begin
                pending      = 1'b1;
                held_addr    = imem_addr;
                new_req      = 1'b1;
                new_req_addr = imem_addr;
                lat          = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            if (lat == 0) begin
                ack_v   = 1'b1;
                pending = 1'b0;
            end else begin
                lat--;
            end
        end
        imem_ack        = ack_v;
        imem_rdata      = ack_v ? word_at(imem_addr) : $urandom;
        stall           = st;
        branch_flag_i   = br;
        branch_target_i = bt;
        flush_i         = fl;
        new_pc_i        = np;
        if (st[1:0] == 2'b00 && inst_o != 32'h0) begin
            check32("deliver_pc", pc_o, exp_pc);
            check32("deliver_inst", inst_o, word_at(pc_o));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (fl) exp_pc = np;
        else if (br && !st[2]) exp_pc = bt;
    endtask

    task automatic do_reset(input bit late_ack);
        @(negedge clk);
        reset         = 1'b1;
        stall         = 6'b000011;
        branch_flag_i = 1'b0;
        flush_i       = 1'b0;
        imem_ack      = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check32("rst_req", {31'b0, imem_req}, 32'd0);
        check32("rst_addr", imem_addr, 32'h0000_0000);
        check32("rst_pc_o", pc_o, 32'h0);
        check32("rst_inst_o", inst_o, 32'h0);
        check32("rst_stallreq", {31'b0, stallreq_o}, 32'd0);
        if (late_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_BAD1;
        end
        pending = 1'b0;
        exp_pc  = 32'h0000_0000;
    endtask

    initial begin
        int          d0;
        bit          found;
        logic [31:0] p_hold;
        logic [31:0] r, bt;
        logic [5:0]  st;

        reset = 1'b1; stall = 6'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
        flush_i = 1'b0; new_pc_i = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        delivered = 0; pending = 1'b0; lat = 0; new_req = 1'b0; exp_pc = 32'h0;

        // Zero-wait memory: one instruction per cycle after the first fetch.
        lat_mode = 0;
        do_reset(1'b0);
        d0 = delivered;
        repeat (8) step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check32("zero_wait_rate", delivered - d0, 32'd7);

        // Three-cycle latency.
        lat_mode = 3;
        repeat (12) step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Stall while a return lands: skid captures it, request drops, output holds.
        lat_mode = 0;
        repeat (3) step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
        p_hold = obs_pc;
        for (int i = 0; i < 3; i++) begin
            step(6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
            check32("hold_req", {31'b0, obs_req}, 32'd0);
            check32("hold_pc", obs_pc, p_hold);
        end
        repeat (6) step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Branch to 0x100 while the request to 0x20 is in flight.
        lat_mode = 2;
        do_reset(1'b0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            if (obs_req && obs_addr == 32'h20) found = 1'b1;
        end
        check32("reach_0x20", {31'b0, found}, 32'd1);
        step(6'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        new_req = 1'b0;
        for (int i = 0; i < 10 && !new_req; i++) step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check32("branch_new_req", {31'b0, new_req}, 32'd1);
        check32("branch_addr", new_req_addr, 32'h100);
        repeat (10) step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Flush and branch together with the skid occupied: flush wins, everything cleared.
        lat_mode = 0;
        repeat (2) step(6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
        step(6'b000011, 1'b1, 32'h100, 1'b1, 32'h180);
        new_req = 1'b0;
        step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check32("flush_pc_clr", obs_pc, 32'h0);
        check32("flush_inst_clr", obs_inst, 32'h0);
        check32("flush_new_req", {31'b0, new_req}, 32'd1);
        check32("flush_addr", new_req_addr, 32'h180);
        repeat (6) step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset mid-transaction followed by a stale ack in IDLE.
        lat_mode = 3;
        repeat (2) step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        do_reset(1'b1);
        lat_mode = 0;
        d0 = delivered;
        repeat (6) step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check32("post_reset_rate", delivered - d0, 32'd5);

        // Randomized traffic, including targets near the top of the address space.
        lat_mode = -1;
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom;
            st = r[5:0];
            if (r[31:28] < 4'd10) st[1:0] = 2'b00;
            bt = $urandom;
            bt = (r[9:8] == 2'b00) ? 32'hFFFF_FFF4 : {20'h0, bt[11:2], 2'b00};
            step(st, (r[15:12] == 4'h0), bt, (r[23:18] == 6'h0), {22'h0, bt[9:2], 2'b00});
        end
        check32("random_progress", {31'b0, (delivered - d0 > 100)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch stage that produces the `pc`/`inst` pair consumed by the IF/ID pipeline register.
- Owns the program counter and drives a variable-latency instruction-memory request/acknowledge interface.
- Absorbs one early return in a single-entry skid buffer.
- Applies branch and flush redirects, and raises a stall request to the pipeline controller whenever it has no valid instruction to hand over.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
stall  in  6  pipeline stall vector from controller; bits 0,1,2 used (`Stop`/`NotStop`)
branch_flag_i  in  1  ID-stage branch taken, qualified by stall[2]==NotStop
branch_target_i  in  32  branch destination
flush_i  in  1  exception flush, unqualified, highest priority
new_pc_i  in  32  flush destination (handler address)
imem_req  out  1  instruction memory request, registered
imem_addr  out  32  request address, registered, stable while imem_req=1 and no ack
imem_ack  in  1  one-cycle completion strobe; imem_rdata valid same cycle
imem_rdata  in  32  returned instruction word
pc_o  out  32  address of presented instruction (to IF/ID)
inst_o  out  32  presented instruction (to IF/ID)
stallreq_o  out  1  fetch cannot supply an instruction this cycle

Behaviour:
- Reset:
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - pc_o=0, inst_o=0, out_valid=0, skid_valid=0, discard=0, stallreq_o=0.
- Definitions:
  - adv = (stall[0]==NotStop && stall[1]==NotStop). IF/ID captures pc_o/inst_o on an adv edge.
  - acc = ack arriving in WAIT with discard=0 and no redirect this cycle.
  - redirect = flush_i, or (branch_flag_i && stall[2]==NotStop). Target is new_pc_i if flush_i is set, else branch_target_i.
- States: IDLE, WAIT, HOLD.
  - IDLE: one cycle after reset, then go to WAIT with imem_req=1 and imem_addr=pc. imem_ack is ignored in IDLE.
  - WAIT, no ack: imem_req stays 1 and imem_addr is held. If adv or !out_valid, the output register becomes a bubble (pc_o=0, inst_o=0, out_valid=0); otherwise it holds.
  - WAIT, acc, and slot free (adv or !out_valid):
    - pc_o<=pc, inst_o<=imem_rdata, out_valid<=1.
    - pc<=pc+PC_STEP (mod 2^32, wraps FFFF_FFFC->0000_0000).
    - Stay in WAIT; imem_addr<=pc+PC_STEP.
    - Throughput: one instruction per cycle with a zero-wait memory.
  - WAIT, acc, slot busy (out_valid && !adv): skid<={pc,imem_rdata}, skid_valid<=1, pc<=pc+PC_STEP, imem_req<=0, go to HOLD.
  - HOLD: output register holds. On adv: output<=skid, skid_valid<=0, imem_req<=1, imem_addr<=pc, go to WAIT.
- Redirect (any state):
  - pc<=target; output register and skid invalidated (zeros) after the edge.
  - The instruction in pc_o/inst_o at the redirect edge is delivered only if adv (delay slot).
  - WAIT with no ack this cycle: the outstanding request cannot be withdrawn. Set discard=1. On its ack, drop the data, clear discard, and set imem_addr<=pc (target) with imem_req=1.
  - WAIT with ack this cycle: drop the data, imem_addr<=target, stay in WAIT.
  - IDLE/HOLD: go to WAIT, imem_req=1, imem_addr=target.
  - flush_i and branch together: flush wins.
  - A second redirect while discard=1 updates pc only; still exactly one ack is dropped.
- stallreq_o = (state!=IDLE) && !out_valid. Combinational from registers; no path from imem_ack.
- Reset mid-transaction: reset wins. imem_req=0 on the next cycle; a late ack while in IDLE is ignored.
- Invariants:
  - At most one outstanding memory request.
  - imem_addr never changes while imem_req=1 and ack is pending.
  - pc_o/inst_o change only on adv, on a load into a free slot, or on redirect.

Decomposition:
- Shared defines (existing defines header): InstAddrBus, InstBus, Zero32h, Stop/NotStop, Enable.
- New constants added there: the FSM state encodings IDLE/WAIT/HOLD (2-bit).
- One sub-module: if_skid_buf (single-entry {pc,inst} register with valid, load, unload, clear).
- PC/FSM logic stays in if_fetch.

Test Plan:
- Reset, zero-wait memory (ack same cycle as req), stall=0 -> imem_addr 0,4,8,... on consecutive cycles; pc_o/inst_o follow one cycle later; stallreq_o=0 after first ack.
- Memory latency 3 cycles -> stallreq_o=1 for 3 cycles per fetch; pc_o/inst_o=0 during the wait; imem_addr held constant until ack.
- stall=6'b000011 held 4 cycles while an ack arrives -> skid captures it, imem_req drops, pc_o holds. On release, the skid instruction appears next and fetch resumes at pc+4.
- branch_flag_i=1, target 0x100, while a request to 0x20 is outstanding with latency 2 -> the 0x20 data is discarded, next imem_addr=0x100, and 0x24 is never presented.
- flush_i with new_pc_i=0x180 and branch_flag_i in the same cycle -> fetch resumes at 0x180; skid and output cleared.
- Reset asserted mid-WAIT with a late ack following -> imem_req=0 and all outputs 0 next cycle; the ack is ignored; refetch from RESET_PC.
